// File: rtl/shift_counter_gen.sv
// Shift-register sequence generator: Johnson (period 2*WIDTH) or ring (period WIDTH),
// with up/down stepping, checked parallel load, position index and wrap/error pulses.
//
//   state   | meaning
//   JOHNSON | q walks the thermometer sequence, seed 0...0, period 2*WIDTH
//   RING    | q rotates a single 1, seed 0...01, period WIDTH
module shift_counter_gen #(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  typedef enum logic {JOHNSON = 1'b0, RING = 1'b1} mode_t;

  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(2*WIDTH - 1);
  localparam logic [IDX_W-1:0] R_LAST = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] R_SEED = WIDTH'(1);

  mode_t            mode_q, mode_d, mode_sel;
  logic [WIDTH-1:0] q_d;
  logic [IDX_W-1:0] idx_d, last;
  logic             wrap_d, err_d;
  logic             legal;
  logic [IDX_W-1:0] load_idx;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int p = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) p++;
    return p;
  endfunction

  // A Johnson pattern is a (possibly empty) run of ones at one end: at most one bit change.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
    int t = 0;
    for (int i = 0; i < WIDTH-1; i++) if (v[i] != v[i+1]) t++;
    return (t <= 1);
  endfunction

  function automatic logic [IDX_W-1:0] johnson_idx(input logic [WIDTH-1:0] v);
    int p = popcount(v);
    if (v[0])        return IDX_W'(p);
    else if (p == 0) return '0;
    else             return IDX_W'(2*WIDTH - p);
  endfunction

  function automatic logic [IDX_W-1:0] ring_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= JOHNSON;
      q      <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      q      <= q_d;
      idx    <= idx_d;
      wrap   <= wrap_d;
      err    <= err_d;
    end
  end

  always_comb begin
    mode_sel = mode ? RING : JOHNSON;
    mode_d   = mode_q;
    q_d      = q;
    idx_d    = idx;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    last     = (mode_q == RING) ? R_LAST : J_LAST;

    // Load legality follows the requested mode, not the current one.
    if (mode_sel == RING) begin
      legal    = (popcount(load_val) == 1);
      load_idx = ring_idx(load_val);
    end else begin
      legal    = johnson_legal(load_val);
      load_idx = johnson_idx(load_val);
    end

    if (load) begin
      if (legal) begin
        q_d    = load_val;
        idx_d  = load_idx;
        mode_d = mode_sel;
      end else begin
        err_d = 1'b1;
      end
    end else if (mode_sel != mode_q) begin
      mode_d = mode_sel;
      q_d    = (mode_sel == RING) ? R_SEED : '0;
      idx_d  = '0;
    end else if (en) begin
      if (mode_q == RING)
        q_d = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
      else
        q_d = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
      if (dir) idx_d = (idx == '0)  ? last : idx - 1'b1;
      else     idx_d = (idx == last) ? '0  : idx + 1'b1;
      wrap_d = (idx_d == '0);
    end
  end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench for shift_counter_gen (WIDTH=4): stimulus queues expected outputs,
// a monitor pops and compares one entry per clock edge (or per async-reset probe).
module tb_shift_counter_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] idx;
  logic       wrap, err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] q;
    logic [2:0] idx;
    logic       wrap;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  event async_ev;

  shift_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .idx(idx), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic compare_one();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (q !== e.q || idx !== e.idx || wrap !== e.wrap || err !== e.err) begin
      failures++;
      $display("FAIL %s: got q=%b idx=%0d wrap=%b err=%b, want q=%b idx=%0d wrap=%b err=%b",
               e.name, q, idx, wrap, err, e.q, e.idx, e.wrap, e.err);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) compare_one();
  end

  always @(async_ev) begin
    #1;
    if (sb.size() > 0) compare_one();
  end

  task automatic push(input logic [3:0] eq, input logic [2:0] ei, input logic ew,
                      input logic ee, input string nm);
    exp_t e;
    e.q = eq; e.idx = ei; e.wrap = ew; e.err = ee; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive inputs for the next rising edge and queue what that edge must produce.
  task automatic step(input logic s_en, input logic s_mode, input logic s_dir,
                      input logic s_load, input logic [3:0] s_lv,
                      input logic [3:0] eq, input logic [2:0] ei, input logic ew,
                      input logic ee, input string nm);
    @(negedge clk);
    en = s_en; mode = s_mode; dir = s_dir; load = s_load; load_val = s_lv;
    push(eq, ei, ew, ee, nm);
  endtask

  logic [3:0] t1_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] t2_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #3;
    push(4'b0000, 3'd0, 1'b0, 1'b0, "reset_state");
    -> async_ev;
    @(negedge clk);
    rst = 1'b1;

    // Johnson up through a full period
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 0, 4'h0, t1_q[i], 3'((i + 1) % 8), (i == 7), 0, $sformatf("johnson_up_%0d", i));

    // Switch to ring: reseed ignores en, then a full ring period
    step(1, 1, 0, 0, 4'h0, 4'b0001, 3'd0, 0, 0, "ring_reseed");
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, 4'h0, t2_q[i], 3'((i + 1) % 4), (i == 3), 0, $sformatf("ring_up_%0d", i));

    // Down counting
    step(1, 1, 1, 0, 4'h0, 4'b1000, 3'd3, 0, 0, "ring_down_0");
    step(1, 1, 1, 0, 4'h0, 4'b0100, 3'd2, 0, 0, "ring_down_1");
    step(1, 0, 1, 0, 4'h0, 4'b0000, 3'd0, 0, 0, "johnson_reseed");
    step(1, 0, 1, 0, 4'h0, 4'b1000, 3'd7, 0, 0, "johnson_down_0");
    step(1, 0, 1, 0, 4'h0, 4'b1100, 3'd6, 0, 0, "johnson_down_1");

    // Loads and legality
    step(0, 0, 0, 1, 4'b0111, 4'b0111, 3'd3, 0, 0, "johnson_load_0111");
    step(0, 0, 0, 1, 4'b0101, 4'b0111, 3'd3, 0, 1, "johnson_load_0101_err");
    step(0, 0, 0, 0, 4'h0,    4'b0111, 3'd3, 0, 0, "err_clears");
    step(0, 1, 0, 1, 4'b0110, 4'b0111, 3'd3, 0, 1, "ring_load_0110_err");
    step(0, 1, 0, 0, 4'h0,    4'b0001, 3'd0, 0, 0, "mode_change_retried");
    step(0, 1, 0, 1, 4'b0100, 4'b0100, 3'd2, 0, 0, "ring_load_0100");
    step(1, 1, 1, 0, 4'h0,    4'b0010, 3'd1, 0, 0, "ring_down_a");
    step(1, 1, 1, 0, 4'h0,    4'b0001, 3'd0, 1, 0, "ring_down_wrap");
    step(1, 1, 0, 0, 4'h0,    4'b0010, 3'd1, 0, 0, "ring_dir_flip");
    step(0, 0, 0, 1, 4'b1100, 4'b1100, 3'd6, 0, 0, "load_with_mode_change");
    step(1, 0, 0, 0, 4'h0,    4'b1000, 3'd7, 0, 0, "johnson_up_from_load");
    step(1, 0, 0, 0, 4'h0,    4'b0000, 3'd0, 1, 0, "johnson_wrap_after_load");

    // Async reset mid-count, with err high just before it
    step(1, 0, 0, 0, 4'h0,    4'b0001, 3'd1, 0, 0, "pre_reset_0");
    step(1, 0, 0, 0, 4'h0,    4'b0011, 3'd2, 0, 0, "pre_reset_1");
    step(1, 0, 0, 1, 4'b0101, 4'b0011, 3'd2, 0, 1, "pre_reset_err");
    @(negedge clk);
    #2;
    rst = 1'b0;
    push(4'b0000, 3'd0, 1'b0, 1'b0, "async_reset");
    -> async_ev;
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b1;
    step(1, 0, 0, 0, 4'h0, 4'b0001, 3'd1, 0, 0, "resume_0");
    step(1, 0, 0, 0, 4'h0, 4'b0011, 3'd2, 0, 0, "resume_1");

    // Hold, load without en, load beats en
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 4'h0, 4'b0011, 3'd2, 0, 0, $sformatf("hold_%0d", i));
    step(0, 0, 0, 1, 4'b1111, 4'b1111, 3'd4, 0, 0, "load_no_en");
    step(1, 0, 0, 1, 4'b0001, 4'b0001, 3'd1, 0, 0, "load_beats_en");
    step(1, 0, 0, 0, 4'h0,    4'b0011, 3'd2, 0, 0, "step_after_load");

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
